load_align_unit: RTL and testbench

//  Sequential load-data formatter between the data-memory port and register writeback.

---
 rtl/load_align_unit_if.sv | 47 ++++
 rtl/load_align_unit.sv | 211 +++++++++++++++++++++
 tb/tb_load_align_unit.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_align_unit_if.sv
// Load-align unit bus bundle: request, memory read and response channels.
//   slave  : modport used by load_align_unit
//   master : modport used by the requester / memory side
// Signals
//   req_valid/req_ready/req_funct3/req_addr/exc_in/exc_inst : load request
//   mem_rd_en/mem_rd_addr/mem_rd_valid/mem_rd_data          : word read port
//   rsp_valid/rsp_ready/rsp_data/rsp_misaligned             : formatted result
interface load_align_unit_if #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned BUS_W  = 64,
    parameter int unsigned ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic              exc_in;
    logic [7:0]        exc_inst;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_valid;
    logic [BUS_W-1:0]  mem_rd_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    logic              rsp_misaligned;

    modport slave (
        input  req_valid, req_funct3, req_addr, exc_in, exc_inst,
        output req_ready,
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_valid, mem_rd_data,
        output rsp_valid, rsp_data, rsp_misaligned,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_funct3, req_addr, exc_in, exc_inst,
        input  req_ready,
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_valid, mem_rd_data,
        input  rsp_valid, rsp_data, rsp_misaligned,
        output rsp_ready
    );
endinterface

// File: rtl/load_align_unit.sv
// load_align_unit: sequential load-data formatter between the data-memory
// read port and register writeback. Issues one (or, for word-crossing loads
// with splitting enabled, two) aligned reads, extracts the addressed bytes
// and sign/zero-extends them according to funct3.
// Ports
//   clk      : clock, all state on rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : load_align_unit_if.slave (request, memory read, response)
// Build option
//   MISALIGNED_SPLIT_EN : when defined, word-crossing loads use two reads and
//                         rsp_misaligned is tied 0; otherwise they complete
//                         immediately with rsp_data=0, rsp_misaligned=1.
module load_align_unit #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned BUS_W  = 64,
    parameter int unsigned ADDR_W = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    load_align_unit_if.slave   bus
);

    localparam int unsigned BYTES = BUS_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned SZ_W  = OFF_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT0 = 2'd1,
        ST_WAIT1 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state;
    logic              req_ready_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rsp_valid_q;
    logic [XLEN-1:0]   rsp_data_q;
    logic [2:0]        f3_q;
    logic [OFF_W-1:0]  off_q;
`ifdef MISALIGNED_SPLIT_EN
    logic              cross_q;
    logic [BUS_W-1:0]  word0_q;
`else
    logic              mis_q;
`endif

    logic [OFF_W-1:0]  off_c;
    logic [SZ_W-1:0]   size_c;
    logic              cross_c;
    logic              illegal_c;
    logic [ADDR_W-1:0] aligned_c;

    // Request decode: byte offset, access size and word-crossing detection
    always_comb begin
        off_c     = bus.req_addr[OFF_W-1:0];
        aligned_c = {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
        case (bus.req_funct3[1:0])
            2'b00:   size_c = SZ_W'(1);
            2'b01:   size_c = SZ_W'(2);
            2'b10:   size_c = SZ_W'(4);
            default: size_c = SZ_W'(8);
        endcase
        // raw returns the whole word from offset 0
        if (bus.req_funct3 == 3'b111) begin
            off_c  = '0;
            size_c = SZ_W'(BYTES);
        end
        cross_c   = (SZ_W'(off_c) + size_c) > SZ_W'(BYTES);
        // ld/lwu have no meaning on a 32-bit datapath
        illegal_c = (XLEN == 32) &&
                    ((bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110));
    end

    // Shift the double word down to the addressed byte, then extend per funct3
    function automatic logic [XLEN-1:0] extract(
        input logic [2*BUS_W-1:0] dw,
        input logic [OFF_W-1:0]   off,
        input logic [2:0]         f3
    );
        logic [XLEN-1:0] sh;
        sh = XLEN'(dw >> {off, 3'b000});
        case (f3)
            3'b000:  extract = XLEN'($signed(sh[7:0]));
            3'b001:  extract = XLEN'($signed(sh[15:0]));
            3'b010:  extract = XLEN'($signed(sh[31:0]));
            3'b011:  extract = sh;
            3'b100:  extract = XLEN'(sh[7:0]);
            3'b101:  extract = XLEN'(sh[15:0]);
            3'b110:  extract = XLEN'(sh[31:0]);
            3'b111:  extract = dw[XLEN-1:0];
        endcase
    endfunction

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            req_ready_q <= 1'b1;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            f3_q        <= '0;
            off_q       <= '0;
`ifdef MISALIGNED_SPLIT_EN
            cross_q     <= 1'b0;
            word0_q     <= '0;
`else
            mis_q       <= 1'b0;
`endif
        end else begin
            rd_en_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        req_ready_q <= 1'b0;
                        f3_q        <= bus.req_funct3;
                        off_q       <= off_c;
`ifdef MISALIGNED_SPLIT_EN
                        cross_q     <= cross_c;
`endif
                        if (bus.exc_in) begin
                            rsp_data_q  <= XLEN'(bus.exc_inst);
`ifndef MISALIGNED_SPLIT_EN
                            mis_q       <= 1'b0;
`endif
                            rsp_valid_q <= 1'b1;
                            state       <= ST_RESP;
                        end else if (illegal_c) begin
                            rsp_data_q  <= '0;
`ifndef MISALIGNED_SPLIT_EN
                            mis_q       <= 1'b0;
`endif
                            rsp_valid_q <= 1'b1;
                            state       <= ST_RESP;
                        end
`ifndef MISALIGNED_SPLIT_EN
                        else if (cross_c) begin
                            rsp_data_q  <= '0;
                            mis_q       <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state       <= ST_RESP;
                        end
`endif
                        else begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= aligned_c;
                            state     <= ST_WAIT0;
                        end
                    end
                end
                ST_WAIT0: begin
                    if (bus.mem_rd_valid) begin
`ifdef MISALIGNED_SPLIT_EN
                        word0_q <= bus.mem_rd_data;
                        if (cross_q) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= rd_addr_q + ADDR_W'(BYTES);
                            state     <= ST_WAIT1;
                        end else begin
                            rsp_data_q  <= extract({BUS_W'(0), bus.mem_rd_data}, off_q, f3_q);
                            rsp_valid_q <= 1'b1;
                            state       <= ST_RESP;
                        end
`else
                        rsp_data_q  <= extract({BUS_W'(0), bus.mem_rd_data}, off_q, f3_q);
                        mis_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= ST_RESP;
`endif
                    end
                end
`ifdef MISALIGNED_SPLIT_EN
                ST_WAIT1: begin
                    if (bus.mem_rd_valid) begin
                        rsp_data_q  <= extract({bus.mem_rd_data, word0_q}, off_q, f3_q);
                        rsp_valid_q <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
`endif
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_rd_addr = rd_addr_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
`ifdef MISALIGNED_SPLIT_EN
    assign bus.rsp_misaligned = 1'b0;
`else
    assign bus.rsp_misaligned = mis_q;
`endif

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: directed vectors, backpressure,
// mid-operation reset and a short random run against a byte-level model.
module tb_load_align_unit;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    load_align_unit_if bus();

    load_align_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [63:0] data;
        logic        mis;
        int          lat;
        int          nreads;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          mem_lat  = 1;
    int          last_acc_cyc = 0;
    int          rsp_first_cyc = 0;
    bit          in_rsp = 1'b0;
    logic [63:0] rd_log[$];
    logic [63:0] pend_addr[$];
    int          pend_due[$];
    logic [63:0] mem_words [logic [63:0]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] memword(input logic [63:0] a);
        if (mem_words.exists(a)) return mem_words[a];
        return {a[31:0] ^ 32'h5A3C_96E1, ~a[31:0] + 32'h1357_9BDF};
    endfunction

    function automatic exp_t mk(input logic [63:0] d, input logic m, input int lat, input int nr);
        exp_t e;
        e.data = d; e.mis = m; e.lat = lat; e.nreads = nr;
        return e;
    endfunction

    // Byte-level reference: gather bytes across up to two words, then extend
    function automatic exp_t model(input logic [2:0] f3, input logic [63:0] addr,
                                   input logic exc, input logic [7:0] inst, input int lat);
        exp_t e;
        int off, size;
        logic [63:0] al, w0, w1, r;
        al  = {addr[63:3], 3'b000};
        off = int'(addr[2:0]);
        case (f3[1:0])
            2'b00:   size = 1;
            2'b01:   size = 2;
            2'b10:   size = 4;
            default: size = 8;
        endcase
        if (f3 == 3'b111) begin size = 8; off = 0; end
        e.mis = 1'b0; e.data = '0;
        if (exc) begin
            e.data = {56'h0, inst}; e.lat = 0; e.nreads = 0;
            return e;
        end
        if (off + size > 8) begin
`ifdef MISALIGNED_SPLIT_EN
            e.nreads = 2; e.lat = 2 * lat + 2;
`else
            e.mis = 1'b1; e.lat = 0; e.nreads = 0;
            return e;
`endif
        end else begin
            e.nreads = 1; e.lat = lat + 1;
        end
        w0 = memword(al);
        w1 = memword(al + 64'd8);
        r  = '0;
        for (int i = 0; i < size; i++) begin
            if (off + i < 8) r[8*i +: 8] = w0[8*(off+i) +: 8];
            else             r[8*i +: 8] = w1[8*(off+i-8) +: 8];
        end
        if (!f3[2] && size < 8 && r[8*size-1])
            for (int i = size; i < 8; i++) r[8*i +: 8] = 8'hFF;
        e.data = r;
        return e;
    endfunction

    // Memory: log reads on the falling edge, answer mem_lat cycles later
    always @(negedge clk) begin
        if (bus.mem_rd_en === 1'b1) begin
            rd_log.push_back(bus.mem_rd_addr);
            pend_addr.push_back(bus.mem_rd_addr);
            pend_due.push_back(cyc + mem_lat);
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = 64'hDEAD_DEAD_DEAD_DEAD;
        if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = memword(pend_addr[0]);
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
        end
    end

    // Response monitor: scoreboard pop on handshake
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && bus.rsp_valid === 1'b1) begin
            if (!in_rsp) begin
                in_rsp = 1'b1;
                rsp_first_cyc = cyc;
            end
            if (bus.rsp_ready === 1'b1) begin
                in_rsp = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_data", bus.rsp_data, e.data);
                    check("rsp_mis", 64'(bus.rsp_misaligned), 64'(e.mis));
                    check("rsp_lat", 64'(rsp_first_cyc - last_acc_cyc), 64'(e.lat));
                end
            end
        end
    end

    task automatic drive_req(input logic [2:0] f3, input logic [63:0] addr,
                             input logic exc, input logic [7:0] inst);
        bit acc = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.exc_in     = exc;
        bus.exc_inst   = inst;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                acc = 1'b1;
                last_acc_cyc = cyc + 1;
            end
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        bus.exc_in    = 1'b0;
        if (!acc) check("req_accept", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check("rsp_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        #1;
    endtask

    task automatic run_load(input logic [2:0] f3, input logic [63:0] addr, input logic exc,
                            input logic [7:0] inst, input int lat, input exp_t e);
        int n0 = rd_log.size();
        logic [63:0] al = {addr[63:3], 3'b000};
        mem_lat = lat;
        sb.push_back(e);
        drive_req(f3, addr, exc, inst);
        wait_done();
        check("nreads", 64'(rd_log.size() - n0), 64'(e.nreads));
        if (e.nreads > 0 && rd_log.size() > n0) check("rd_addr0", rd_log[n0], al);
        if (e.nreads > 1 && rd_log.size() > n0 + 1) check("rd_addr1", rd_log[n0+1], al + 64'd8);
    endtask

    initial begin
        bit seen;
        logic [2:0]  rf3;
        logic [63:0] raddr;
        logic        rexc;
        logic [7:0]  rinst;
        int          rlat;

        bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_addr = '0;
        bus.exc_in = 1'b0; bus.exc_inst = '0; bus.rsp_ready = 1'b1;
        bus.mem_rd_valid = 1'b0; bus.mem_rd_data = '0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
        check("rst_mem_rd_addr", bus.mem_rd_addr, 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data", bus.rsp_data, 64'd0);
        check("rst_rsp_mis", 64'(bus.rsp_misaligned), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // lb with sign bit set
        mem_words[64'h1000] = 64'h0123_4567_8000_0000;
        run_load(3'b000, 64'h1003, 1'b0, 8'h0, 1, mk(64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2, 1));

        // lhu / lh on the top halfword
        mem_words[64'h1000] = 64'h8001_1111_2222_3333;
        run_load(3'b101, 64'h1006, 1'b0, 8'h0, 2, mk(64'h0000_0000_0000_8001, 1'b0, 3, 1));
        run_load(3'b001, 64'h1006, 1'b0, 8'h0, 3, mk(64'hFFFF_FFFF_FFFF_8001, 1'b0, 4, 1));

        // lw crossing into the next word
        mem_words[64'h1000] = 64'hBEEF_0000_0000_0000;
        mem_words[64'h1008] = 64'h0000_0000_0000_8EAD;
`ifdef MISALIGNED_SPLIT_EN
        run_load(3'b010, 64'h1006, 1'b0, 8'h0, 1, mk(64'hFFFF_FFFF_8EAD_BEEF, 1'b0, 4, 2));
        run_load(3'b001, 64'h1007, 1'b0, 8'h0, 2, mk(64'hFFFF_FFFF_FFFF_ADBE, 1'b0, 6, 2));
`else
        run_load(3'b010, 64'h1006, 1'b0, 8'h0, 1, mk(64'h0, 1'b1, 0, 0));
        run_load(3'b001, 64'h1007, 1'b0, 8'h0, 2, mk(64'h0, 1'b1, 0, 0));
`endif
        // aligned ld, raw, lwu, lb at the last byte of a word
        run_load(3'b011, 64'h1008, 1'b0, 8'h0, 2, mk(64'h0000_0000_0000_8EAD, 1'b0, 3, 1));
        run_load(3'b111, 64'h1005, 1'b0, 8'h0, 1, mk(64'hBEEF_0000_0000_0000, 1'b0, 2, 1));
        run_load(3'b110, 64'h1004, 1'b0, 8'h0, 1, mk(64'h0000_0000_BEEF_0000, 1'b0, 2, 1));
        run_load(3'b000, 64'h1007, 1'b0, 8'h0, 1, mk(64'hFFFF_FFFF_FFFF_FFBE, 1'b0, 2, 1));

        // exception overrides everything, including a crossing access
        run_load(3'b011, 64'h1000, 1'b1, 8'h73, 1, mk(64'h73, 1'b0, 0, 0));
        run_load(3'b010, 64'h1006, 1'b1, 8'h73, 1, mk(64'h73, 1'b0, 0, 0));

        // response backpressure
        mem_words[64'h1000] = 64'h0000_0000_0000_F200;
        bus.rsp_ready = 1'b0;
        mem_lat = 1;
        sb.push_back(mk(64'hF2, 1'b0, 2, 1));
        drive_req(3'b100, 64'h1001, 1'b0, 8'h0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.rsp_valid === 1'b1);
        end
        check("hold_rsp_seen", 64'(seen), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'(bus.rsp_valid), 64'd1);
            check("hold_data", bus.rsp_data, 64'hF2);
            check("hold_req_ready", 64'(bus.req_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_done();
        @(negedge clk);
        check("release_req_ready", 64'(bus.req_ready), 64'd1);
        check("release_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk); #1;

        // reset while waiting for read data; the late data must be ignored
        mem_words[64'h2000] = 64'hDEAD_BEEF_0123_4567;
        mem_lat = 4;
        drive_req(3'b011, 64'h2000, 1'b0, 8'h0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("midrst_req_ready", 64'(bus.req_ready), 64'd1);
        check("midrst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
        check("midrst_mem_rd_addr", bus.mem_rd_addr, 64'd0);
        check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("midrst_rsp_data", bus.rsp_data, 64'd0);
        check("midrst_rsp_mis", 64'(bus.rsp_misaligned), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("late_data_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        check("late_data_pending", 64'(pend_due.size()), 64'd0);
        @(posedge clk); #1;
        run_load(3'b011, 64'h2000, 1'b0, 8'h0, 1, mk(64'hDEAD_BEEF_0123_4567, 1'b0, 2, 1));

        // random loads against the byte-level model
        for (int n = 0; n < 24; n++) begin
            rf3   = 3'($urandom_range(0, 7));
            raddr = 64'h3000 + 64'($urandom_range(0, 31));
            rexc  = ($urandom_range(0, 7) == 0);
            rinst = 8'($urandom_range(0, 255));
            rlat  = int'($urandom_range(1, 3));
            run_load(rf3, raddr, rexc, rinst, rlat, model(rf3, raddr, rexc, rinst, rlat));
        end

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
